// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage multiply/divide bus: ID/EX operands and control in, HI/LO and hazard status out.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             FlushE;
  logic             StartE;
  logic [1:0]       OpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             WriteHiE;
  logic             WriteLoE;
  logic             BusyE;
  logic             DoneE;
  logic [WIDTH-1:0] HiE;
  logic [WIDTH-1:0] LoE;

  modport master (
    output FlushE, StartE, OpE, SrcAE, SrcBE, WriteHiE, WriteLoE,
    input  BusyE, DoneE, HiE, LoE
  );

  modport slave (
    input  FlushE, StartE, OpE, SrcAE, SrcBE, WriteHiE, WriteLoE,
    output BusyE, DoneE, HiE, LoE
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply (divide stays iterative).
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic             CLK,
  input logic             rst,
  ex_muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  // MUL: {partial product, multiplier}; DIV: {remainder, dividend shifting into quotient}
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 is_div_q, neg_q, rneg_q, div0_q;
  logic                 busy_q, done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 sgn_a, sgn_b, last_iter, div_ge;
  logic [WIDTH-1:0]     mag_a, mag_b, div_diff, rem_fix, quo_fix;
  logic [WIDTH:0]       mul_sum, div_part;
  logic [2*WIDTH-1:0]   mul_step, div_step, prod;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0]   prod_fast;
`endif

  always_comb begin
    sgn_a     = ~bus.OpE[0] & bus.SrcAE[WIDTH-1];
    sgn_b     = ~bus.OpE[0] & bus.SrcBE[WIDTH-1];
    mag_a     = sgn_a ? -bus.SrcAE : bus.SrcAE;
    mag_b     = sgn_b ? -bus.SrcBE : bus.SrcBE;
    last_iter = (cnt_q == CNT_W'(WIDTH-1));
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    // Remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
    div_part  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_part >= {1'b0, opnd_q});
    div_diff  = div_part[WIDTH-1:0] - opnd_q;
    div_step  = {(div_ge ? div_diff : div_part[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    prod      = neg_q ? -acc_q : acc_q;
    rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    quo_fix   = div0_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
`ifdef MULDIV_FAST_MUL_EN
    prod_fast = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.FlushE) begin
            state_q <= IDLE;
          end else if (bus.StartE) begin
            cnt_q    <= '0;
            is_div_q <= bus.OpE[1];
            neg_q    <= sgn_a ^ sgn_b;
            rneg_q   <= sgn_a;
            div0_q   <= (bus.SrcBE == '0);
            opnd_q   <= bus.OpE[1] ? mag_b : mag_a;
`ifdef MULDIV_FAST_MUL_EN
            if (!bus.OpE[1]) begin
              acc_q   <= prod_fast;
              state_q <= DONE;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, mag_a};
              state_q <= DIV;
              busy_q  <= 1'b1;
            end
`else
            acc_q   <= {{WIDTH{1'b0}}, (bus.OpE[1] ? mag_a : mag_b)};
            state_q <= bus.OpE[1] ? DIV : MUL;
            busy_q  <= 1'b1;
`endif
          end else begin
            if (bus.WriteHiE) hi_q <= bus.SrcAE;
            if (bus.WriteLoE) lo_q <= bus.SrcAE;
          end
        end
        MUL, DIV: begin
          if (bus.FlushE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= (state_q == MUL) ? mul_step : div_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          // The instruction has left EX, so a flush here must not cancel the commit.
          hi_q    <= is_div_q ? rem_fix : prod[2*WIDTH-1:WIDTH];
          lo_q    <= is_div_q ? quo_fix : prod[WIDTH-1:0];
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BusyE = busy_q;
  assign bus.DoneE = done_q;
  assign bus.HiE   = hi_q;
  assign bus.LoE   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboarded random + directed bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic CLK = 1'b0;
  logic rst = 1'b0;

  ex_muldiv_unit_if #(.WIDTH(W)) bus();
  ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.CLK(CLK), .rst(rst), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           k;
    int           lat;
    int           busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, busy_run = 0, last_run = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] hi, output logic [W-1:0] lo);
    logic [2*W-1:0] xa, xb, p;
    if (!op[1]) begin
      xa = op[0] ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
      xb = op[0] ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
      p  = xa * xb;
      hi = p[2*W-1:W];
      lo = p[W-1:0];
    end else if (b == '0) begin
      hi = a;
      lo = '1;
    end else if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = a;
        hi = '0;
      end else begin
        lo = $signed(a) / $signed(b);
        hi = $signed(a) % $signed(b);
      end
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Monitor: measures busy run length and checks every DoneE against the scoreboard.
  initial forever begin
    @(negedge CLK);
    if (bus.BusyE) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
    if (bus.DoneE) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("hi", 64'(bus.HiE), 64'(e.hi));
        chk("lo", 64'(bus.LoE), 64'(e.lo));
        chk("latency", 64'(cyc - e.k), 64'(e.lat));
        if (e.busy != 0) chk("busy_cycles", 64'(last_run), 64'(e.busy));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] h, l;
    bit fm;
    ref_model(op, a, b, h, l);
    fm = FAST && !op[1];
    sb.push_back('{hi: h, lo: l, k: cyc + 1, lat: fm ? 1 : W + 1, busy: fm ? 0 : W});
  endtask

  task automatic start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    push_exp(op, a, b);
    bus.OpE = op; bus.SrcAE = a; bus.SrcBE = b; bus.StartE = 1'b1;
    tick();
    bus.StartE = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0 = done_cnt;
    bit got = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
    start(op, a, b);
    wait_done(nm);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return W'($urandom_range(0, 15));
      5: return -W'($urandom_range(1, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int d0;
    logic [W-1:0] a, b;
    bus.FlushE = 0; bus.StartE = 0; bus.OpE = 0; bus.SrcAE = 0; bus.SrcBE = 0;
    bus.WriteHiE = 0; bus.WriteLoE = 0;

    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(bus.BusyE), 64'd0);
    chk("rst_done", 64'(bus.DoneE), 64'd0);
    chk("rst_hi", 64'(bus.HiE), 64'd0);
    chk("rst_lo", 64'(bus.LoE), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    run(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
    run(2'b10, -32'd7, 32'd2, "div_neg7_2");
    run(2'b11, 32'd7, 32'd0, "divu_by0");
    run(2'b10, 32'hFFFF_FFF9, 32'd0, "div_by0_signed");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

    // mtlo alone
    bus.WriteLoE = 1'b1; bus.SrcAE = 32'hABCD;
    tick();
    bus.WriteLoE = 1'b0;
    @(negedge CLK);
    chk("mtlo", 64'(bus.LoE), 64'h ABCD);
    tick();

    // flush at busy cycle 10 of a MULTU, HI/LO preloaded
    bus.WriteHiE = 1'b1; bus.SrcAE = 32'h11; tick();
    bus.WriteHiE = 1'b0; bus.WriteLoE = 1'b1; bus.SrcAE = 32'h22; tick();
    bus.WriteLoE = 1'b0;
    d0 = done_cnt;
    bus.OpE = 2'b01; bus.SrcAE = 32'h1234_5678; bus.SrcBE = 32'h0000_0F0F; bus.StartE = 1'b1;
    tick();
    bus.StartE = 1'b0;
    repeat (9) tick();
    bus.FlushE = 1'b1;
    tick();
    bus.FlushE = 1'b0;
    @(negedge CLK);
    chk("flush_busy", 64'(bus.BusyE), 64'd0);
    repeat (40) tick();
    chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
    chk("flush_hi", 64'(bus.HiE), 64'h11);
    chk("flush_lo", 64'(bus.LoE), 64'h22);

    // StartE held through the whole operation
    d0 = done_cnt;
    a = W'($urandom); b = W'($urandom_range(1, 1000));
    push_exp(2'b11, a, b);
    bus.OpE = 2'b11; bus.SrcAE = a; bus.SrcBE = b; bus.StartE = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      bus.SrcAE = W'($urandom); bus.SrcBE = W'($urandom);
    end
    bus.StartE = 1'b0;
    repeat (40) tick();
    chk("held_start_one_done", 64'(done_cnt - d0), 64'd1);

    // StartE with WriteHiE: start wins, mthi dropped
    bus.WriteHiE = 1'b1; bus.SrcAE = 32'h55; tick();
    bus.WriteHiE = 1'b0;
    push_exp(2'b11, 32'd9, 32'd4);
    bus.OpE = 2'b11; bus.SrcAE = 32'd9; bus.SrcBE = 32'd4; bus.StartE = 1'b1; bus.WriteHiE = 1'b1;
    tick();
    bus.StartE = 1'b0; bus.WriteHiE = 1'b0;
    @(negedge CLK);
    chk("start_beats_mthi", 64'(bus.HiE), 64'h55);
    wait_done("start_mthi");

    for (int i = 0; i < 1500; i++) begin
      run(2'($urandom_range(0, 3)), pick(), pick(), "random");
    end

    // asynchronous reset in the middle of a divide
    start(2'b10, 32'h7654_3210, 32'd3);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.BusyE), 64'd0);
    chk("midrst_done", 64'(bus.DoneE), 64'd0);
    chk("midrst_hi", 64'(bus.HiE), 64'd0);
    chk("midrst_lo", 64'(bus.LoE), 64'd0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
    run(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, "multu_after_rst");
    repeat (5) tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
